// File: rtl/cache_pkg.sv
// Shared types and address helpers for the cache lookup controller.
// Default geometry: 2-way, 16 sets, 256-byte lines, 32-bit addresses.
package cache_pkg;

  localparam int N_WAYS      = 2;
  localparam int N_POW       = 4;
  localparam int TAG_BITS    = 20;
  localparam int SET_BITS    = 4;
  localparam int OFFSET_BITS = 8;
  localparam int ADDR_BITS   = TAG_BITS + SET_BITS + OFFSET_BITS;
  localparam int N_SETS      = 2 ** SET_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    RESP,
    FLUSH
  } state_e;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] a);
    return a[ADDR_BITS-1 -: TAG_BITS];
  endfunction

  function automatic logic [SET_BITS-1:0] addr_set(input logic [ADDR_BITS-1:0] a);
    return a[OFFSET_BITS +: SET_BITS];
  endfunction

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [ADDR_BITS-1:0] a);
    return a[OFFSET_BITS-1:0];
  endfunction

  function automatic logic [ADDR_BITS-1:0] line_addr(input logic [ADDR_BITS-1:0] a);
    return {a[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/victim_select.sv
// Combinational replacement choice: lowest-index invalid way, otherwise the
// set's round-robin pointer (used_ptr tells the caller to advance it).
module victim_select #(
  parameter int N_WAYS = 2,
  parameter int N_POW  = 4
) (
  input  logic [N_WAYS-1:0] valid,
  input  logic [N_POW-1:0]  rr_ptr,
  output logic [N_POW-1:0]  victim,
  output logic              used_ptr
);

  always_comb begin
    victim   = rr_ptr;
    used_ptr = 1'b1;
    // Scan downward so the lowest invalid way is the last one assigned.
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim   = N_POW'(w);
        used_ptr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Single-requester set-associative lookup/refill sequencer owning tag+valid state.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_lookup_ctrl #(
  parameter int N_WAYS      = cache_pkg::N_WAYS,
  parameter int N_POW       = cache_pkg::N_POW,
  parameter int TAG_BITS    = cache_pkg::TAG_BITS,
  parameter int SET_BITS    = cache_pkg::SET_BITS,
  parameter int OFFSET_BITS = cache_pkg::OFFSET_BITS,
  localparam int ADDR_BITS  = TAG_BITS + SET_BITS + OFFSET_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [N_POW-1:0]     resp_way,
  output logic [SET_BITS-1:0]  resp_set,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  input  logic                 mem_resp_valid,
  output logic                 fill_en,
  output logic [N_POW-1:0]     fill_way,
  output logic [SET_BITS-1:0]  fill_set,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);
  import cache_pkg::*;

  localparam int N_SETS = 2 ** SET_BITS;
  localparam int WAY_IW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

  state_e                                     state;
  logic [TAG_BITS-1:0]                        lat_tag;
  logic [SET_BITS-1:0]                        lat_set;
  logic [N_SETS-1:0][N_WAYS-1:0][TAG_BITS-1:0] tag_arr;
  logic [N_SETS-1:0][N_WAYS-1:0]              valid_arr;
  logic [N_SETS-1:0][N_POW-1:0]               rr_ptr;
  logic [N_POW-1:0]                           victim;
  logic                                       victim_rr;
  logic [WAY_IW-1:0]                          victim_idx;
  logic [SET_BITS-1:0]                        flush_idx;
  logic [N_WAYS-1:0]                          way_match;
  logic                                       hit;
  logic [N_POW-1:0]                           hit_way;
  logic [N_POW-1:0]                           vs_way;
  logic                                       vs_rr;
  logic                                       unused_offset;

  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];
  assign victim_idx    = victim[WAY_IW-1:0];
  assign req_ready     = (state == IDLE) && !flush && !rst;

  for (genvar w = 0; w < N_WAYS; w++) begin : g_cmp
    assign way_match[w] = valid_arr[lat_set][w] && (tag_arr[lat_set][w] == lat_tag);
  end

  // Lowest matching way wins if duplicates ever appear.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) begin
        hit     = 1'b1;
        hit_way = N_POW'(w);
      end
    end
  end

  victim_select #(
    .N_WAYS (N_WAYS),
    .N_POW  (N_POW)
  ) u_victim_select (
    .valid    (valid_arr[lat_set]),
    .rr_ptr   (rr_ptr[lat_set]),
    .victim   (vs_way),
    .used_ptr (vs_rr)
  );

  // Tag storage needs no reset: a tag is only trusted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == FILL) tag_arr[lat_set][victim_idx] <= lat_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_tag       <= '0;
      lat_set       <= '0;
      valid_arr     <= '0;
      rr_ptr        <= '0;
      victim        <= '0;
      victim_rr     <= 1'b0;
      flush_idx     <= '0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_way      <= '0;
      resp_set      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      fill_en       <= 1'b0;
      fill_way      <= '0;
      fill_set      <= '0;
    end else begin
      resp_valid <= 1'b0;
      fill_en    <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            flush_idx <= '0;
            state     <= FLUSH;
          end else if (req_valid) begin
            lat_tag <= req_addr[ADDR_BITS-1 -: TAG_BITS];
            lat_set <= req_addr[OFFSET_BITS +: SET_BITS];
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_way   <= hit_way;
            resp_set   <= lat_set;
            state      <= RESP;
          end else begin
            victim        <= vs_way;
            victim_rr     <= vs_rr;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {lat_tag, lat_set, {OFFSET_BITS{1'b0}}};
            state         <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_resp_valid) begin
            fill_en  <= 1'b1;
            fill_way <= victim;
            fill_set <= lat_set;
            state    <= FILL;
          end
        end
        FILL: begin
          valid_arr[lat_set][victim_idx] <= 1'b1;
          if (victim_rr)
            rr_ptr[lat_set] <= (rr_ptr[lat_set] == N_POW'(N_WAYS - 1)) ? '0
                             : rr_ptr[lat_set] + N_POW'(1);
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          resp_way   <= victim;
          resp_set   <= lat_set;
          state      <= RESP;
        end
        RESP: state <= IDLE;
        FLUSH: begin
          valid_arr[flush_idx] <= '0;
          flush_idx            <= flush_idx + SET_BITS'(1);
          if (flush_idx == SET_BITS'(N_SETS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating counters; flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == RESP) begin
      if (resp_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Scoreboard bench for cache_lookup_ctrl: stimulus queues expected responses,
// memory requests and fills; a negedge monitor pops and compares them.
module tb_cache_lookup_ctrl;
  import cache_pkg::*;

  typedef struct {
    logic       hit;
    logic [3:0] way;
    logic [3:0] set;
    bit         chk_lat;
  } resp_exp_t;

  typedef struct {
    logic [3:0] way;
    logic [3:0] set;
  } fill_exp_t;

  logic                 clk, rst;
  logic                 req_valid, req_ready, flush;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 resp_valid, resp_hit;
  logic [N_POW-1:0]     resp_way;
  logic [SET_BITS-1:0]  resp_set;
  logic                 mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [ADDR_BITS-1:0] mem_req_addr;
  logic                 fill_en;
  logic [N_POW-1:0]     fill_way;
  logic [SET_BITS-1:0]  fill_set;
  logic [31:0]          hit_count, miss_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_accept = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  resp_exp_t        resp_q[$];
  logic [31:0]      mem_q[$];
  fill_exp_t        fill_q[$];

  localparam logic [31:0] A  = 32'h1234_5600;
  localparam logic [31:0] B  = 32'hABCD_E600;
  localparam logic [31:0] C  = 32'h5555_5600;
  localparam logic [31:0] BP = 32'h0000_A3FF;
  localparam logic [31:0] RS = 32'h7777_7800;

  cache_lookup_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .resp_set       (resp_set),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .fill_en        (fill_en),
    .fill_way       (fill_way),
    .fill_set       (fill_set),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT-presented event against the queued expectation.
  resp_exp_t   m_r;
  fill_exp_t   m_f;
  logic [31:0] m_a;
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else begin
          m_r = resp_q.pop_front();
          check("resp_hit", 32'(resp_hit), 32'(m_r.hit));
          check("resp_way", 32'(resp_way), 32'(m_r.way));
          check("resp_set", 32'(resp_set), 32'(m_r.set));
          if (m_r.chk_lat) check("hit_latency", 32'(cyc - last_accept), 32'd2);
        end
      end
      if (mem_req_valid && mem_q.size() == 0) check("mem_req_unexpected", 32'd1, 32'd0);
      if (mem_req_valid && mem_req_ready && mem_q.size() != 0) begin
        m_a = mem_q.pop_front();
        check("mem_req_addr", mem_req_addr, m_a);
      end
      if (fill_en) begin
        if (fill_q.size() == 0) check("fill_unexpected", 32'd1, 32'd0);
        else begin
          m_f = fill_q.pop_front();
          check("fill_way", 32'(fill_way), 32'(m_f.way));
          check("fill_set", 32'(fill_set), 32'(m_f.set));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 60) begin tick(); n++; end
    if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
  endtask

  // One request; a miss is served by an inline memory model with optional backpressure.
  task automatic access(input logic [31:0] addr, input bit exp_hit, input int exp_way, input int bp);
    resp_exp_t e;
    fill_exp_t f;
    int n;
    e.hit = exp_hit; e.way = 4'(exp_way); e.set = addr_set(addr); e.chk_lat = exp_hit;
    resp_q.push_back(e);
    if (exp_hit) exp_hits++;
    else begin
      exp_miss++;
      mem_q.push_back(line_addr(addr));
      f.way = 4'(exp_way); f.set = addr_set(addr);
      fill_q.push_back(f);
    end
    wait_ready();
    req_valid = 1'b1; req_addr = addr; last_accept = cyc;
    tick();
    req_valid = 1'b0;
    if (!exp_hit) begin
      n = 0;
      while (!mem_req_valid && n < 20) begin tick(); n++; end
      if (!mem_req_valid) check("mem_req_timeout", 32'd0, 32'd1);
      for (int i = 0; i < bp; i++) begin
        mem_resp_valid = 1'b1;
        check("bp_mem_req_valid", 32'(mem_req_valid), 32'd1);
        check("bp_mem_req_addr", mem_req_addr, line_addr(addr));
        check("bp_req_ready", 32'(req_ready), 32'd0);
        tick();
      end
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      tick(); tick();
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
    end
    n = 0;
    while (resp_q.size() != 0 && n < 50) begin tick(); n++; end
    check("resp_pending", 32'(resp_q.size()), 32'd0);
    check("mem_pending", 32'(mem_q.size()), 32'd0);
    check("fill_pending", 32'(fill_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_hit"}, 32'(resp_hit), 32'd0);
    check({tag, "_resp_way"}, 32'(resp_way), 32'd0);
    check({tag, "_resp_set"}, 32'(resp_set), 32'd0);
    check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 32'd0);
    check({tag, "_fill_en"}, 32'(fill_en), 32'd0);
    check({tag, "_fill_way"}, 32'(fill_way), 32'd0);
    check({tag, "_fill_set"}, 32'(fill_set), 32'd0);
    check({tag, "_hit_count"}, hit_count, 32'd0);
    check({tag, "_miss_count"}, miss_count, 32'd0);
  endtask

  task automatic check_counts(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, "_hit_count"}, hit_count, 32'(exp_hits));
    check({tag, "_miss_count"}, miss_count, 32'(exp_miss));
`else
    check({tag, "_hit_count"}, hit_count, 32'd0);
    check({tag, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    #1;
    check("post_reset_req_ready", 32'(req_ready), 32'd1);

    access(A, 1'b0, 0, 0);        // cold miss -> way0, set6
    access(A, 1'b1, 0, 0);        // rehit, 2-cycle latency
    access(B, 1'b0, 1, 0);        // lowest invalid way
    access(C, 1'b0, 0, 0);        // set full, pointer 0 -> 1
    access(A, 1'b0, 1, 0);        // pointer 1 wraps to 0
    access(A, 1'b1, 1, 0);
    access(B, 1'b0, 0, 0);        // pointer 0 -> 1
    access(BP, 1'b0, 0, 5);       // backpressure, offset bits dropped
    access(BP, 1'b1, 0, 0);
    check_counts("pre_flush");

    // flush and a request together: flush wins
    wait_ready();
    flush = 1'b1; req_valid = 1'b1; req_addr = A;
    #1;
    check("flush_prio_req_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    n = 0;
    while (!req_ready && n < 40) begin n++; tick(); end
    check("flush_busy_cycles", 32'(n), 32'd16);

    access(A, 1'b0, 0, 0);        // invalidated
    access(C, 1'b0, 1, 0);
    access(B, 1'b0, 1, 0);        // pointer survived flush at 1
    check_counts("post_flush");

    // reset in the middle of a refill
    wait_ready();
    mem_q.push_back(line_addr(RS));
    req_valid = 1'b1; req_addr = RS;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 20) begin tick(); n++; end
    check("rs_mem_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tick(); tick();
    rst = 1'b0;
    exp_hits = 0; exp_miss = 0;
    #1;
    check("rs_req_ready", 32'(req_ready), 32'd1);
    check("rs_mem_pending", 32'(mem_q.size()), 32'd0);
    access(A, 1'b0, 0, 0);
    access(A, 1'b1, 0, 0);
    check_counts("post_midreset");

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
